processing_unit: RTL and testbench
==================================

PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 Parameter: WORD_SIZE, 8, datapath and address width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Load_R0, Load_R1, Load_R2, Load_R3  input  1 each  load the selected general register from Bus_2.
REQ-005 Load_PC  input  1  load PC from Bus_2.
REQ-006 Inc_PC  input  1  increment PC by 1.
REQ-007 Load_IR, Load_Add_R, Load_Reg_Y  input  1 each  load IR, Add_R or Reg_Y from Bus_2.
REQ-008 Load_Reg_Z  input  1  capture the ALU zero flag (and carry flag, REQ-029).
REQ-009 Sel_Bus_1_Mux  input  3  Bus_1 source select.
REQ-010 Sel_Bus_2_Mux  input  2  Bus_2 source select.
REQ-011 mem_word  input  WORD_SIZE  memory read data, combinational from address.
REQ-012 instruction  output  WORD_SIZE  IR contents.
REQ-013 address  output  WORD_SIZE  Add_R contents.
REQ-014 Bus_1  output  WORD_SIZE  memory write data.
REQ-015 Zflag  output  1  registered zero flag.
REQ-016 Cflag  output  1  registered carry/borrow flag.

Function
REQ-017 Bus_1 SHALL be combinational: select 0..3 -> R0..R3, 4 -> PC, 5..7 and X -> 0.
REQ-018 Bus_2 SHALL be combinational: select 0 -> alu_out, 1 -> Bus_1, 2 -> mem_word, 3 and X -> 0.
REQ-019 ALU operands SHALL be Reg_Y (A) and Bus_1 (B); opcode SHALL be instruction[7:4].
REQ-020 The ALU SHALL compute ADD (1) A+B, SUB (2) B-A, AND (3) A&B, NOT (4) ~B; all other opcodes SHALL give 0; results wrap modulo 2^WORD_SIZE.
REQ-021 alu_zero SHALL be 1 iff alu_out equals 0.
REQ-022 Each Load_* SHALL write its register from Bus_2 at the clock edge; multiple loads in one cycle SHALL all take the same Bus_2 value.
REQ-023 PC: Load_PC SHALL take priority over Inc_PC; Inc_PC alone SHALL give PC+1, wrapping 0xFF -> 0x00.
REQ-024 Zflag SHALL update only when Load_Reg_Z=1, otherwise hold.
REQ-025 All register outputs SHALL reflect new values one cycle after their load strobe; the datapath has no other latency.

Reset
REQ-026 rst=0 SHALL clear R0-R3, PC, IR, Add_R, Reg_Y, Zflag and Cflag to 0 immediately, independent of clk.
REQ-027 Reset asserted mid-instruction SHALL discard all pending loads; the first edge after release SHALL honour the strobes present then.

Configuration
REQ-028 Macro PU_CARRY_FLAG_EN SHALL select carry-flag support.
REQ-029 With it defined: on Load_Reg_Z, Cflag SHALL capture the ADD carry-out or the SUB borrow (B<A), and 0 for other opcodes.
REQ-030 Without it: Cflag SHALL be tied 0, no carry logic SHALL be built, and all other behaviour SHALL be identical.

Structure
REQ-031 The shared package risc_spm_pkg SHALL hold the opcode constants (NOP..BRZ), the Bus_1/Bus_2 select encodings and WORD_SIZE.
REQ-032 The ALU SHALL be a separate sub-module risc_alu (combinational: alu_out, alu_zero, alu_carry); all state SHALL stay in processing_unit.

Verification
REQ-033 Reset: assert rst=0 with all loads active -> every register output 0, Zflag=0.
REQ-034 Fetch: PC=0x05, Sel1=4, Sel2=1, Load_Add_R -> address=0x05; then mem_word=0x1B, Sel2=2, Load_IR, Inc_PC -> instruction=0x1B, PC=0x06.
REQ-035 SUB to zero: R2=0x07, R3=0x07, opcode SUB, Reg_Y<-R2, then Sel1=3, Sel2=0, Load_R3, Load_Reg_Z -> R3=0x00, Zflag=1, Cflag=0.
REQ-036 ADD overflow (PU_CARRY_FLAG_EN defined): Reg_Y=0xF0, R0=0x20, opcode ADD -> R0=0x10, Zflag=0, Cflag=1; without the macro -> Cflag=0.
REQ-037 PC priority and wrap: PC=0xFF with Inc_PC -> 0x00; Load_PC and Inc_PC together with mem_word=0x40 -> PC=0x40.
REQ-038 Invalid select: Sel1=6, Sel2=1, Load_R1 -> R1=0x00.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC stored-program machine: word size,
// instruction opcodes and the Bus_1 / Bus_2 source-select encodings.
package risc_spm_pkg;

    localparam int WORD_SIZE = 8;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        AND = 4'd3,
        NOT = 4'd4,
        RD  = 4'd5,
        WR  = 4'd6,
        BR  = 4'd7,
        BRZ = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        SEL1_R0 = 3'd0,
        SEL1_R1 = 3'd1,
        SEL1_R2 = 3'd2,
        SEL1_R3 = 3'd3,
        SEL1_PC = 3'd4
    } bus1_sel_t;

    typedef enum logic [1:0] {
        SEL2_ALU  = 2'd0,
        SEL2_BUS1 = 2'd1,
        SEL2_MEM  = 2'd2
    } bus2_sel_t;

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU of the processing unit: A is Reg_Y, B is Bus_1.
// Carry/borrow output is only built when PU_CARRY_FLAG_EN is defined.
module risc_alu #(
    parameter int WORD_SIZE = risc_spm_pkg::WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [3:0]           opcode_i,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic                 alu_zero,
    output logic                 alu_carry
);
    import risc_spm_pkg::*;

    always_comb begin
        alu_out = '0;
        case (opcode_t'(opcode_i))
            ADD:     alu_out = a_i + b_i;
            SUB:     alu_out = b_i - a_i;
            AND:     alu_out = a_i & b_i;
            NOT:     alu_out = ~b_i;
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

`ifdef PU_CARRY_FLAG_EN
    logic [WORD_SIZE:0] addWide;

    assign addWide = {1'b0, a_i} + {1'b0, b_i};

    // SUB computes B-A, so a borrow occurs exactly when B < A
    always_comb begin
        alu_carry = 1'b0;
        case (opcode_t'(opcode_i))
            ADD:     alu_carry = addWide[WORD_SIZE];
            SUB:     alu_carry = (b_i < a_i);
            default: alu_carry = 1'b0;
        endcase
    end
`else
    assign alu_carry = 1'b0;
`endif

endmodule

// File: rtl/processing_unit.sv
// Datapath of the RISC stored-program machine: general registers, PC, IR,
// address register, ALU operand register and flags. Macro: PU_CARRY_FLAG_EN.
module processing_unit #(
    parameter int WORD_SIZE = risc_spm_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load_R0,
    input  logic                 Load_R1,
    input  logic                 Load_R2,
    input  logic                 Load_R3,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    input  logic                 Load_IR,
    input  logic                 Load_Add_R,
    input  logic                 Load_Reg_Y,
    input  logic                 Load_Reg_Z,
    input  logic [2:0]           Sel_Bus_1_Mux,
    input  logic [1:0]           Sel_Bus_2_Mux,
    input  logic [WORD_SIZE-1:0] mem_word,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] Bus_1,
    output logic                 Zflag,
    output logic                 Cflag
);
    import risc_spm_pkg::*;

    logic [WORD_SIZE-1:0] r0_q, r1_q, r2_q, r3_q;
    logic [WORD_SIZE-1:0] r0_d, r1_d, r2_d, r3_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] regY_q, regY_d;
    logic                 zflag_q, zflag_d;

    logic [WORD_SIZE-1:0] bus2;
    logic [WORD_SIZE-1:0] aluOut;
    logic                 aluZero;
    logic                 aluCarry;

    always_comb begin
        Bus_1 = '0;
        case (bus1_sel_t'(Sel_Bus_1_Mux))
            SEL1_R0: Bus_1 = r0_q;
            SEL1_R1: Bus_1 = r1_q;
            SEL1_R2: Bus_1 = r2_q;
            SEL1_R3: Bus_1 = r3_q;
            SEL1_PC: Bus_1 = pc_q;
            default: Bus_1 = '0;
        endcase
    end

    always_comb begin
        bus2 = '0;
        case (bus2_sel_t'(Sel_Bus_2_Mux))
            SEL2_ALU:  bus2 = aluOut;
            SEL2_BUS1: bus2 = Bus_1;
            SEL2_MEM:  bus2 = mem_word;
            default:   bus2 = '0;
        endcase
    end

    risc_alu #(.WORD_SIZE(WORD_SIZE)) uAlu (
        .a_i       (regY_q),
        .b_i       (Bus_1),
        .opcode_i  (ir_q[7:4]),
        .alu_out   (aluOut),
        .alu_zero  (aluZero),
        .alu_carry (aluCarry)
    );

    // Every load strobe samples the same Bus_2 value; an explicit PC load beats increment
    always_comb begin
        r0_d    = Load_R0    ? bus2 : r0_q;
        r1_d    = Load_R1    ? bus2 : r1_q;
        r2_d    = Load_R2    ? bus2 : r2_q;
        r3_d    = Load_R3    ? bus2 : r3_q;
        ir_d    = Load_IR    ? bus2 : ir_q;
        addr_d  = Load_Add_R ? bus2 : addr_q;
        regY_d  = Load_Reg_Y ? bus2 : regY_q;
        zflag_d = Load_Reg_Z ? aluZero : zflag_q;
        pc_d    = pc_q;
        if (Load_PC) begin
            pc_d = bus2;
        end else if (Inc_PC) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            regY_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            regY_q  <= regY_d;
            zflag_q <= zflag_d;
        end
    end

`ifdef PU_CARRY_FLAG_EN
    logic cflag_q, cflag_d;

    always_comb begin
        cflag_d = Load_Reg_Z ? aluCarry : cflag_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cflag_q <= 1'b0;
        end else begin
            cflag_q <= cflag_d;
        end
    end

    assign Cflag = cflag_q;
`else
    // The ALU drives a constant 0 carry in this build
    assign Cflag = aluCarry;
`endif

    assign instruction = ir_q;
    assign address     = addr_q;
    assign Zflag       = zflag_q;

endmodule

// File: tb/tb_processing_unit.sv
// Directed self-checking bench for processing_unit; expected carry results
// follow PU_CARRY_FLAG_EN.
module tb_processing_unit;

`ifdef PU_CARRY_FLAG_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC;
    logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic [7:0] mem_word;
    logic [7:0] instruction, address, Bus_1;
    logic       Zflag, Cflag;

    int checks   = 0;
    int failures = 0;

    processing_unit #(.WORD_SIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .Load_R0       (Load_R0),
        .Load_R1       (Load_R1),
        .Load_R2       (Load_R2),
        .Load_R3       (Load_R3),
        .Load_PC       (Load_PC),
        .Inc_PC        (Inc_PC),
        .Load_IR       (Load_IR),
        .Load_Add_R    (Load_Add_R),
        .Load_Reg_Y    (Load_Reg_Y),
        .Load_Reg_Z    (Load_Reg_Z),
        .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
        .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
        .mem_word      (mem_word),
        .instruction   (instruction),
        .address       (address),
        .Bus_1         (Bus_1),
        .Zflag         (Zflag),
        .Cflag         (Cflag)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Load_R0 = 0; Load_R1 = 0; Load_R2 = 0; Load_R3 = 0;
        Load_PC = 0; Inc_PC = 0; Load_IR = 0; Load_Add_R = 0;
        Load_Reg_Y = 0; Load_Reg_Z = 0;
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; mem_word = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic readBus1(input logic [2:0] sel, output logic [7:0] v);
        Sel_Bus_1_Mux = sel;
        #1;
        v = Bus_1;
    endtask

    task automatic loadMem(input logic [7:0] value, input int which);
        idle();
        mem_word = value;
        Sel_Bus_2_Mux = 2'd2;
        case (which)
            0: Load_R0 = 1;
            1: Load_R1 = 1;
            2: Load_R2 = 1;
            3: Load_R3 = 1;
            4: Load_PC = 1;
            5: Load_IR = 1;
            default: Load_Reg_Y = 1;
        endcase
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        idle();
        mem_word = 8'hAA; Sel_Bus_2_Mux = 2'd2;
        Load_R0 = 1; Load_R1 = 1; Load_R2 = 1; Load_R3 = 1; Load_PC = 1;
        Load_IR = 1; Load_Add_R = 1; Load_Reg_Y = 1;
        @(posedge clk); #1;
        Load_Reg_Z = 1;
        #1 rst = 1'b0;
        #1;
        checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL reset_address got=%h exp=00", address); end
        checks++; if (instruction !== 8'h00) begin failures++; $display("[TB] FAIL reset_instruction got=%h exp=00", instruction); end
        checks++; if (Zflag !== 1'b0) begin failures++; $display("[TB] FAIL reset_zflag got=%b exp=0", Zflag); end
        checks++; if (Cflag !== 1'b0) begin failures++; $display("[TB] FAIL reset_cflag got=%b exp=0", Cflag); end
        for (int s = 0; s < 5; s++) begin
            readBus1(3'(s), v);
            checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL reset_bus1_sel%0d got=%h exp=00", s, v); end
        end
        @(posedge clk); #1;
        checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL reset_hold_address got=%h exp=00", address); end
        idle();
        mem_word = 8'h5A; Sel_Bus_2_Mux = 2'd2; Load_R1 = 1;
        rst = 1'b1;
        tick();
        readBus1(3'd1, v);
        checks++; if (v !== 8'h5A) begin failures++; $display("[TB] FAIL reset_release_r1 got=%h exp=5a", v); end
        readBus1(3'd0, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL reset_release_r0 got=%h exp=00", v); end
    endtask

    task automatic test_fetch();
        logic [7:0] v;
        loadMem(8'h05, 4);
        Sel_Bus_1_Mux = 3'd4; Sel_Bus_2_Mux = 2'd1; Load_Add_R = 1;
        tick();
        checks++; if (address !== 8'h05) begin failures++; $display("[TB] FAIL fetch_address got=%h exp=05", address); end
        mem_word = 8'h1B; Sel_Bus_2_Mux = 2'd2; Load_IR = 1; Inc_PC = 1;
        tick();
        checks++; if (instruction !== 8'h1B) begin failures++; $display("[TB] FAIL fetch_instruction got=%h exp=1b", instruction); end
        readBus1(3'd4, v);
        checks++; if (v !== 8'h06) begin failures++; $display("[TB] FAIL fetch_pc got=%h exp=06", v); end
    endtask

    task automatic test_sub();
        logic [7:0] v;
        loadMem(8'h07, 2);
        loadMem(8'h07, 3);
        loadMem(8'h20, 5);
        Sel_Bus_1_Mux = 3'd2; Sel_Bus_2_Mux = 2'd1; Load_Reg_Y = 1;
        tick();
        Sel_Bus_1_Mux = 3'd3; Sel_Bus_2_Mux = 2'd0; Load_R3 = 1; Load_Reg_Z = 1;
        tick();
        readBus1(3'd3, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL sub_zero_r3 got=%h exp=00", v); end
        checks++; if (Zflag !== 1'b1) begin failures++; $display("[TB] FAIL sub_zero_zflag got=%b exp=1", Zflag); end
        checks++; if (Cflag !== 1'b0) begin failures++; $display("[TB] FAIL sub_zero_cflag got=%b exp=0", Cflag); end
        Sel_Bus_1_Mux = 3'd3; Sel_Bus_2_Mux = 2'd0; Load_R0 = 1; Load_Reg_Z = 1;
        tick();
        readBus1(3'd0, v);
        checks++; if (v !== 8'hF9) begin failures++; $display("[TB] FAIL sub_borrow_r0 got=%h exp=f9", v); end
        checks++; if (Zflag !== 1'b0) begin failures++; $display("[TB] FAIL sub_borrow_zflag got=%b exp=0", Zflag); end
        checks++; if (Cflag !== CARRY_EN) begin failures++; $display("[TB] FAIL sub_borrow_cflag got=%b exp=%b", Cflag, CARRY_EN); end
    endtask

    task automatic test_alu_ops();
        logic [7:0] v;
        loadMem(8'hF0, 6);
        loadMem(8'h20, 0);
        loadMem(8'h10, 5);
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R0 = 1; Load_Reg_Z = 1;
        tick();
        readBus1(3'd0, v);
        checks++; if (v !== 8'h10) begin failures++; $display("[TB] FAIL add_ovf_r0 got=%h exp=10", v); end
        checks++; if (Zflag !== 1'b0) begin failures++; $display("[TB] FAIL add_ovf_zflag got=%b exp=0", Zflag); end
        checks++; if (Cflag !== CARRY_EN) begin failures++; $display("[TB] FAIL add_ovf_cflag got=%b exp=%b", Cflag, CARRY_EN); end
        loadMem(8'h00, 5);
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R2 = 1;
        tick();
        readBus1(3'd2, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL nop_r2 got=%h exp=00", v); end
        checks++; if (Zflag !== 1'b0) begin failures++; $display("[TB] FAIL zflag_hold got=%b exp=0", Zflag); end
        checks++; if (Cflag !== CARRY_EN) begin failures++; $display("[TB] FAIL cflag_hold got=%b exp=%b", Cflag, CARRY_EN); end
        loadMem(8'h30, 5);
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R1 = 1;
        tick();
        readBus1(3'd1, v);
        checks++; if (v !== 8'h10) begin failures++; $display("[TB] FAIL and_r1 got=%h exp=10", v); end
        loadMem(8'h40, 5);
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R3 = 1; Load_Reg_Z = 1;
        tick();
        readBus1(3'd3, v);
        checks++; if (v !== 8'hEF) begin failures++; $display("[TB] FAIL not_r3 got=%h exp=ef", v); end
        checks++; if (Cflag !== 1'b0) begin failures++; $display("[TB] FAIL not_cflag got=%b exp=0", Cflag); end
        loadMem(8'h50, 5);
        Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R1 = 1; Load_Reg_Z = 1;
        tick();
        readBus1(3'd1, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL rd_opcode_r1 got=%h exp=00", v); end
        checks++; if (Zflag !== 1'b1) begin failures++; $display("[TB] FAIL rd_opcode_zflag got=%b exp=1", Zflag); end
    endtask

    task automatic test_pc();
        logic [7:0] v;
        loadMem(8'hFF, 4);
        Inc_PC = 1;
        tick();
        readBus1(3'd4, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL pc_wrap got=%h exp=00", v); end
        mem_word = 8'h40; Sel_Bus_2_Mux = 2'd2; Load_PC = 1; Inc_PC = 1;
        tick();
        readBus1(3'd4, v);
        checks++; if (v !== 8'h40) begin failures++; $display("[TB] FAIL pc_priority got=%h exp=40", v); end
    endtask

    task automatic test_invalid_sel();
        logic [7:0] v;
        loadMem(8'h77, 1);
        loadMem(8'h33, 2);
        readBus1(3'd5, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL bus1_sel5 got=%h exp=00", v); end
        Sel_Bus_1_Mux = 3'd6; Sel_Bus_2_Mux = 2'd1; Load_R1 = 1;
        tick();
        readBus1(3'd1, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL invalid_sel1_r1 got=%h exp=00", v); end
        mem_word = 8'h99; Sel_Bus_2_Mux = 2'd3; Load_R2 = 1;
        tick();
        readBus1(3'd2, v);
        checks++; if (v !== 8'h00) begin failures++; $display("[TB] FAIL invalid_sel2_r2 got=%h exp=00", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        mem_word = 8'h3C; Sel_Bus_2_Mux = 2'd2;
        Load_R0 = 1; Load_R1 = 1; Load_R2 = 1; Load_R3 = 1; Load_Add_R = 1;
        tick();
        for (int s = 0; s < 4; s++) begin
            readBus1(3'(s), v);
            checks++; if (v !== 8'h3C) begin failures++; $display("[TB] FAIL multi_load_r%0d got=%h exp=3c", s, v); end
        end
        checks++; if (address !== 8'h3C) begin failures++; $display("[TB] FAIL multi_load_address got=%h exp=3c", address); end
        for (int i = 0; i < 3; i++) begin
            Inc_PC = 1;
            tick();
        end
        readBus1(3'd4, v);
        checks++; if (v !== 8'h43) begin failures++; $display("[TB] FAIL pc_inc_run got=%h exp=43", v); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch();
        test_sub();
        test_alu_ops();
        test_pc();
        test_invalid_sel();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
